// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO access sequencer.
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_ACC = 2'd1,
        IO_REQ  = 2'd2,
        DONE    = 2'd3
    } mio_state_t;

    localparam logic [3:0]  IO_BASE_DEFAULT = 4'hF;
    localparam logic [31:0] BUS_ERR_DATA    = 32'hDEAD_BEEF;

endpackage

// File: rtl/mio_wait_cnt.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module mio_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mio_access_unit.sv
// Memory/IO access sequencer producing MIO_ready for the multicycle control FSM.
// Optional IO ack timeout with sticky bus_err when MIO_TIMEOUT_EN is defined.
import mio_pkg::*;

module mio_access_unit #(
    parameter int         RAM_LAT = 2,
    parameter int         RAM_AW  = 10,
    parameter logic [3:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int         TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              MIO_ready,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack,
    output logic              bus_err
);

`ifdef MIO_TIMEOUT_EN
    localparam int CNT_W = 8;
`else
    localparam int CNT_W = 4;
`endif

    mio_state_t       state;
    logic             we_q;
    logic             req;
    logic             is_io;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    assign req   = MemRead | MemWrite;
    assign is_io = (addr[31:28] == IO_BASE);
    assign busy  = (state != IDLE);

    // Counter is loaded with LAT-1 so its zero flag marks the final wait cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = CNT_W'(RAM_LAT - 1);
        if (state == IDLE && req) begin
            cnt_load = 1'b1;
`ifdef MIO_TIMEOUT_EN
            if (is_io)
                cnt_load_val = CNT_W'(TIMEOUT - 1);
`endif
        end
        if (state == RAM_ACC)
            cnt_dec = 1'b1;
`ifdef MIO_TIMEOUT_EN
        if (state == IO_REQ)
            cnt_dec = 1'b1;
`endif
    end

    mio_wait_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            rdata     <= '0;
            MIO_ready <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
        end else begin
            MIO_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q      <= MemWrite;
                        ram_addr  <= addr[RAM_AW+1:2];
                        ram_wdata <= wdata;
                        io_addr   <= addr;
                        io_wdata  <= wdata;
                        if (is_io) begin
                            state  <= IO_REQ;
                            io_req <= 1'b1;
                            io_we  <= MemWrite;
                        end else begin
                            state  <= RAM_ACC;
                            ram_en <= 1'b1;
                            ram_we <= MemWrite;
                        end
                    end
                end
                RAM_ACC: begin
                    if (cnt_zero) begin
                        if (!we_q)
                            rdata <= ram_rdata;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        MIO_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                IO_REQ: begin
                    // An ack arriving in the expiry cycle takes priority over the timeout.
                    if (io_ack) begin
                        if (!we_q)
                            rdata <= io_rdata;
                        io_req    <= 1'b0;
                        io_we     <= 1'b0;
                        MIO_ready <= 1'b1;
                        state     <= DONE;
                    end
`ifdef MIO_TIMEOUT_EN
                    else if (cnt_zero) begin
                        rdata     <= BUS_ERR_DATA;
                        io_req    <= 1'b0;
                        io_we     <= 1'b0;
                        MIO_ready <= 1'b1;
                        state     <= DONE;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIO_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus_err <= 1'b0;
        else if (state == IO_REQ && !io_ack && cnt_zero)
            bus_err <= 1'b1;
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule
